// File: rtl/button_conditioner.sv
// Synchronizes and debounces the increment/decrement buttons, turning each press into a
// one-cycle pulse with cross-channel interlock; define BUTTON_CONDITIONER_AUTO_REPEAT_EN for hold auto-repeat.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES      = 500000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 5000000,
  parameter logic        BUTTON_ACTIVE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic increment_button_raw,
  input  logic decrement_button_raw,
  output logic increment_pulse,
  output logic decrement_pulse,
  output logic increment_held,
  output logic decrement_held
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam int unsigned TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD_CYCLES - 1);
`else
  logic [63:0] unused_repeat_params;
  assign unused_repeat_params = {REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES};
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HELD    = 2'd1,
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    ST_REPEAT  = 2'd2,
`endif
    ST_BLOCKED = 2'd3
  } state_t;

  // Channel 0 is increment, channel 1 is decrement.
  logic [1:0] raw;
  logic [1:0] sync_meta_q, sync_meta_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] pressed;
  logic [1:0] held_q_vec, held_d_vec, pulse_q_vec;

  assign raw = {decrement_button_raw, increment_button_raw};

  always_comb begin
    sync_meta_d = raw;
    sync_d      = sync_meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_q <= {2{~BUTTON_ACTIVE_LEVEL}};
      sync_q      <= {2{~BUTTON_ACTIVE_LEVEL}};
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
    end
  end

  assign pressed = ~(sync_q ^ {2{BUTTON_ACTIVE_LEVEL}});

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    localparam int OTHER = 1 - gi;

    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            held_q, held_d;
    logic            pulse_q, pulse_d;
    state_t          state_q, state_d;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    logic [TMR_W-1:0] timer_q, timer_d;
`endif
    logic own_rise, own_fall, other_held, other_rise;

    always_comb begin
      cnt_d  = '0;
      held_d = held_q;
      if (pressed[gi] != held_q) begin
        if (cnt_q == DB_LAST) begin
          held_d = pressed[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // The FSM looks at next-cycle held levels so the pulse rises together with held.
    assign own_rise   = held_d & ~held_q;
    assign own_fall   = ~held_d & held_q;
    assign other_held = held_d_vec[OTHER];
    assign other_rise = held_d_vec[OTHER] & ~held_q_vec[OTHER];

    always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      timer_d = timer_q;
`endif
      if (own_fall) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (own_rise) begin
              if (other_held) begin
                state_d = ST_BLOCKED;
              end else begin
                state_d = ST_HELD;
                pulse_d = 1'b1;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
                timer_d = DELAY_LAST;
`endif
              end
            end
          end
          ST_HELD: begin
            if (other_rise) begin
              state_d = ST_BLOCKED;
            end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            else if (timer_q == '0) begin
              state_d = ST_REPEAT;
              pulse_d = 1'b1;
              timer_d = PERIOD_LAST;
            end else begin
              timer_d = timer_q - 1'b1;
            end
`endif
          end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
          ST_REPEAT: begin
            if (other_rise) begin
              state_d = ST_BLOCKED;
            end else if (timer_q == '0) begin
              pulse_d = 1'b1;
              timer_d = PERIOD_LAST;
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
`endif
          ST_BLOCKED: state_d = ST_BLOCKED;
          default:    state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        held_q  <= 1'b0;
        pulse_q <= 1'b0;
        state_q <= ST_IDLE;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        timer_q <= '0;
`endif
      end else begin
        cnt_q   <= cnt_d;
        held_q  <= held_d;
        pulse_q <= pulse_d;
        state_q <= state_d;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        timer_q <= timer_d;
`endif
      end
    end

    assign held_q_vec[gi]  = held_q;
    assign held_d_vec[gi]  = held_d;
    assign pulse_q_vec[gi] = pulse_q;
  end

  assign increment_pulse = pulse_q_vec[0];
  assign decrement_pulse = pulse_q_vec[1];
  assign increment_held  = held_q_vec[0];
  assign decrement_held  = held_q_vec[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: bounce, clean press, auto-repeat, interlock and reset mid-hold,
// with every output checked once per cycle against hand-derived expectations.
module tb_button_conditioner;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam bit AUTO_REPEAT = 1'b1;
`else
  localparam bit AUTO_REPEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic inc_raw;
  logic dec_raw;
  logic increment_pulse;
  logic decrement_pulse;
  logic increment_held;
  logic decrement_held;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES      (4),
    .REPEAT_DELAY_CYCLES  (20),
    .REPEAT_PERIOD_CYCLES (8),
    .BUTTON_ACTIVE_LEVEL  (1'b0)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .increment_button_raw (inc_raw),
    .decrement_button_raw (dec_raw),
    .increment_pulse      (increment_pulse),
    .decrement_pulse      (decrement_pulse),
    .increment_held       (increment_held),
    .decrement_held       (decrement_held)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed %b required %b", tag, cyc, obs, exp);
  endtask

  task automatic check_cycle(input string scen, input logic e_ip, input logic e_dp,
                             input logic e_ih, input logic e_dh);
    check({scen, "/inc_pulse"}, increment_pulse, e_ip);
    check({scen, "/dec_pulse"}, decrement_pulse, e_dp);
    check({scen, "/inc_held"},  increment_held,  e_ih);
    check({scen, "/dec_held"},  decrement_held,  e_dh);
    check({scen, "/exclusive"}, increment_pulse & decrement_pulse, 1'b0);
  endtask

  // Resets the DUT with both buttons released; the next posedge is edge 0.
  task automatic begin_scenario(input string scen);
    inc_raw = 1'b1;
    dec_raw = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cyc = -1;
    check_cycle({scen, "/reset"}, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    inc_raw = 1'b1;
    dec_raw = 1'b1;

    begin_scenario("bounce");
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      cyc = c;
      inc_raw = !((c < 3) || (c == 4) || (c == 5));
      #1;
      check_cycle("bounce", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    $display("bounce scenario done, %0d checks so far", n_checks);

    begin_scenario("clean");
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      cyc = c;
      dec_raw = (c < 10) ? 1'b0 : 1'b1;
      #1;
      check_cycle("clean", 1'b0, (c == 6), 1'b0, (c >= 6 && c <= 15));
    end
    $display("clean press scenario done, %0d checks so far", n_checks);

    begin_scenario("repeat");
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      cyc = c;
      inc_raw = (c < 60) ? 1'b0 : 1'b1;
      #1;
      check_cycle("repeat",
                  AUTO_REPEAT ? (c inside {6, 26, 34, 42, 50, 58}) : (c == 6),
                  1'b0, (c >= 6 && c <= 65), 1'b0);
    end
    $display("auto-repeat scenario done, %0d checks so far", n_checks);

    begin_scenario("interlock");
    for (int c = 0; c < 55; c++) begin
      @(posedge clk); #1;
      cyc = c;
      inc_raw = (c < 40) ? 1'b0 : 1'b1;
      dec_raw = (c >= 10 && c < 30) ? 1'b0 : 1'b1;
      #1;
      check_cycle("interlock", (c == 6), 1'b0, (c >= 6 && c <= 45), (c >= 16 && c <= 35));
    end
    $display("interlock scenario done, %0d checks so far", n_checks);

    begin_scenario("both");
    for (int c = 0; c < 35; c++) begin
      @(posedge clk); #1;
      cyc = c;
      inc_raw = (c < 20) ? 1'b0 : 1'b1;
      dec_raw = (c < 20) ? 1'b0 : 1'b1;
      #1;
      check_cycle("both", 1'b0, 1'b0, (c >= 6 && c <= 25), (c >= 6 && c <= 25));
    end
    $display("simultaneous press scenario done, %0d checks so far", n_checks);

    begin_scenario("rst_hold");
    for (int c = 0; c < 46; c++) begin
      @(posedge clk); #1;
      cyc = c;
      inc_raw = 1'b0;
      reset_n = (c == 30) ? 1'b0 : 1'b1;
      #1;
      check_cycle("rst_hold",
                  (c == 6) || (AUTO_REPEAT && c == 26) || (c == 37),
                  1'b0, (c >= 6 && c <= 29) || (c >= 37), 1'b0);
    end
    $display("reset mid-hold scenario done, %0d checks so far", n_checks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
